// File: rtl/ipv4_rx_hdr_fsm.sv
// IPv4 receive header sequencer: walks 16-bit frame words, validates the header, forwards payload.
// Optional header checksum verification is enabled by defining IPV4_HDR_CSUM_EN.
module ipv4_rx_hdr_fsm #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic              cancel_i,
  input  logic              match_fail_v_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              fsm_idle_v_o,
  output logic              fsm_head_v_o,
  output logic              data_v_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_last_o,
  output logic              data_odd_o,
  output logic              pkt_ok_v_o,
  output logic              drop_v_o,
  output logic              hdr_err_v_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2,
    S_SKIP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        ihl_q, ihl_d;
  logic [LEN_W-1:0]  tot_len_q, tot_len_d;
  logic              odd_q, odd_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              drop_q, drop_d;
  logic              hdr_err_q, hdr_err_d;
  logic              idle_q, head_q;

  logic [LEN_W-1:0]  hdr_bytes;
  logic [IDX_W-1:0]  last_idx;
  logic [LEN_W-1:0]  pay_words;
  logic              hdr_last;
  logic              len_bad;
  logic              trunc_head;
  logic              csum_bad;

  assign hdr_bytes = LEN_W'({ihl_q, 2'b00});
  assign last_idx  = IDX_W'({ihl_q, 1'b0}) - IDX_W'(1);
  // tot_len >= 4*IHL is guaranteed before this is used, so the subtract cannot wrap.
  assign pay_words = (tot_len_q - hdr_bytes + LEN_W'(1)) >> 1;
  assign hdr_last  = (idx_q == last_idx);
  assign len_bad   = (idx_q == IDX_W'(1)) && (LEN_W'(data_i) < hdr_bytes);
  assign trunc_head = last_i & ~(hdr_last & (pay_words == '0));

`ifdef IPV4_HDR_CSUM_EN
  logic [15:0] csum_q, csum_d;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;

  assign csum_sum  = {1'b0, csum_q} + {1'b0, data_i[15:0]};
  assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign csum_bad  = hdr_last && (csum_next != 16'hFFFF);
`else
  assign csum_bad  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    ihl_d     = ihl_q;
    tot_len_d = tot_len_q;
    odd_d     = odd_q;
    pkt_ok_d  = 1'b0;
    drop_d    = 1'b0;
    hdr_err_d = 1'b0;
`ifdef IPV4_HDR_CSUM_EN
    csum_d    = csum_q;
`endif
    if (cancel_i) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else if (valid_i && start_i) begin
      // A start word always begins a new header walk, abandoning whatever was in flight.
      hdr_err_d = (state_q == S_HEAD) || (state_q == S_DATA);
      ihl_d     = data_i[11:8];
      rem_d     = '0;
`ifdef IPV4_HDR_CSUM_EN
      csum_d    = data_i[15:0];
`endif
      if (last_i) begin
        hdr_err_d = 1'b1;
        state_d   = S_IDLE;
      end else if ((data_i[15:12] != 4'd4) || (data_i[11:8] < 4'd5)) begin
        hdr_err_d = 1'b1;
        state_d   = S_SKIP;
      end else begin
        state_d = S_HEAD;
        idx_d   = IDX_W'(1);
      end
    end else if (valid_i) begin
      case (state_q)
        S_HEAD: begin
          idx_d = idx_q + IDX_W'(1);
`ifdef IPV4_HDR_CSUM_EN
          csum_d = csum_next;
`endif
          if (idx_q == IDX_W'(1)) tot_len_d = LEN_W'(data_i);
          if (len_bad || csum_bad || trunc_head) begin
            hdr_err_d = 1'b1;
            state_d   = last_i ? S_IDLE : S_SKIP;
          end else if (match_fail_v_i) begin
            drop_d  = 1'b1;
            state_d = last_i ? S_IDLE : S_SKIP;
          end else if (hdr_last) begin
            if (pay_words == '0) begin
              pkt_ok_d = 1'b1;
              state_d  = last_i ? S_IDLE : S_SKIP;
            end else begin
              state_d = S_DATA;
              rem_d   = pay_words;
              odd_d   = tot_len_q[0];
            end
          end
        end
        S_DATA: begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            pkt_ok_d = 1'b1;
            state_d  = last_i ? S_IDLE : S_SKIP;
          end else if (last_i) begin
            hdr_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_SKIP: begin
          if (last_i) state_d = S_IDLE;
        end
        default: begin
        end
      endcase
    end
    if (state_d != S_HEAD) idx_d = '0;
    drop_d = drop_d | hdr_err_d;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      pkt_ok_q  <= 1'b0;
      drop_q    <= 1'b0;
      hdr_err_q <= 1'b0;
      idle_q    <= 1'b1;
      head_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      pkt_ok_q  <= pkt_ok_d;
      drop_q    <= drop_d;
      hdr_err_q <= hdr_err_d;
      idle_q    <= (state_d == S_IDLE);
      head_q    <= (state_d == S_HEAD);
    end
  end

  // Header field captures are pure data and only read once the walk has loaded them.
  always_ff @(posedge clk) begin
    ihl_q     <= ihl_d;
    tot_len_q <= tot_len_d;
    odd_q     <= odd_d;
`ifdef IPV4_HDR_CSUM_EN
    csum_q    <= csum_d;
`endif
  end

  assign idx_o        = idx_q;
  assign fsm_idle_v_o = idle_q;
  assign fsm_head_v_o = head_q;
  assign pkt_ok_v_o   = pkt_ok_q;
  assign drop_v_o     = drop_q;
  assign hdr_err_v_o  = hdr_err_q;

  assign data_v_o    = valid_i & ~start_i & ~cancel_i & (state_q == S_DATA);
  assign data_o      = data_i;
  assign data_last_o = data_v_o & (rem_q == LEN_W'(1));
  assign data_odd_o  = data_last_o & odd_q;

endmodule
